// File: rtl/uc_pkg.sv
// Shared definitions for the multi-cycle accumulator CPU control unit:
// opcodes, FSM states, next-PC source encodings and the instruction classifier.
package uc_pkg;

  localparam logic [5:0] OP_FIN  = 6'b111111;
  localparam logic [5:0] OP_NOP  = 6'b111110;
  localparam logic [5:0] OP_JMP  = 6'b001001;
  localparam logic [5:0] OP_JZ   = 6'b001010;
  localparam logic [5:0] OP_JNZ  = 6'b001011;
  localparam logic [5:0] OP_JC   = 6'b011001;
  localparam logic [5:0] OP_JNC  = 6'b011010;
  localparam logic [5:0] OP_CALL = 6'b101001;
  localparam logic [5:0] OP_RET  = 6'b101010;
  localparam logic [5:0] OP_OUTR = 6'b001110;
  localparam logic [5:0] OP_IN   = 6'b011110;

  localparam logic [1:0] SPC_INC = 2'b00;
  localparam logic [1:0] SPC_IMM = 2'b01;
  localparam logic [1:0] SPC_RET = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  typedef enum logic [3:0] {
    IC_NOP,
    IC_FIN,
    IC_ALU,
    IC_LDI,
    IC_JMP,
    IC_JZ,
    IC_JNZ,
    IC_JC,
    IC_JNC,
    IC_CALL,
    IC_RET,
    IC_OUTI,
    IC_OUTR,
    IC_IN
  } iclass_t;

  // Exact opcodes are matched before the xx0xxx / xx1000 / xx1100 patterns;
  // every exact opcode has bit 3 set, so none of them can alias an ALU op.
  function automatic iclass_t decode(input logic [5:0] code);
    iclass_t cls;
    case (code)
      OP_FIN:  cls = IC_FIN;
      OP_NOP:  cls = IC_NOP;
      OP_JMP:  cls = IC_JMP;
      OP_JZ:   cls = IC_JZ;
      OP_JNZ:  cls = IC_JNZ;
      OP_JC:   cls = IC_JC;
      OP_JNC:  cls = IC_JNC;
      OP_CALL: cls = IC_CALL;
      OP_RET:  cls = IC_RET;
      OP_OUTR: cls = IC_OUTR;
      OP_IN:   cls = IC_IN;
      default: begin
        if (!code[3])                cls = IC_ALU;
        else if (code[2:0] == 3'b000) cls = IC_LDI;
        else if (code[2:0] == 3'b100) cls = IC_OUTI;
        else                          cls = IC_NOP;
      end
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/uc_ret_stack.sv
// Return-address LIFO for CALL/RET. Pushes into a full stack and pops from an
// empty one are ignored; the caller decides how to treat those cases.
module uc_ret_stack #(
  parameter  int PCW         = 10,
  parameter  int STACK_DEPTH = 8,
  localparam int SPW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [PCW-1:0] push_data,
  output logic [SPW-1:0] sp,
  output logic           full,
  output logic           empty,
  output logic [PCW-1:0] top
);

  localparam int IW = $clog2(STACK_DEPTH);

  logic [PCW-1:0] mem [STACK_DEPTH];
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  rd_idx;

  assign full   = (sp == SPW'(STACK_DEPTH));
  assign empty  = (sp == '0);
  assign wr_idx = IW'(sp);
  assign rd_idx = IW'(sp - 1'b1);
  // Raw top entry; only meaningful while the stack is non-empty.
  assign top    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; sp alone says which
  // entries are live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/uc_seq_ctrl.sv
// Multi-cycle FETCH/EXEC control unit: registered Z/C flags, carry jumps,
// CALL/RET through a return stack and valid/ready handshakes on the I/O ports.
module uc_seq_ctrl
  import uc_pkg::*;
#(
  parameter  int PCW         = 10,
  parameter  int STACK_DEPTH = 8,
  parameter  int NPORTS      = 4,
  localparam int PSW         = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic [PSW-1:0]    port_idx,
  input  logic [PCW-1:0]    pc_cur,
  input  logic              z_alu,
  input  logic              c_alu,
  output logic [2:0]        op,
  output logic              we3,
  output logic              s_inm,
  output logic              s_e,
  output logic              s_s,
  output logic              s_mem_rd2,
  output logic              pc_we,
  output logic [1:0]        s_pc,
  output logic [PCW-1:0]    ret_addr,
  output logic [NPORTS-1:0] in_ready,
  input  logic [NPORTS-1:0] in_valid,
  output logic [NPORTS-1:0] out_valid,
  input  logic [NPORTS-1:0] out_ready,
  output logic              halted,
  output logic              stack_err
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);

  state_t            state;
  state_t            state_nxt;
  logic [5:0]        ir;
  logic              zr;
  logic              cr;
  iclass_t           cls;
  logic [NPORTS-1:0] port_sel;
  logic              in_hs;
  logic              out_hs;
  logic              flags_we;
  logic              err_set;
  logic              push;
  logic              pop;
  logic [PCW-1:0]    push_data;
  logic [SPW-1:0]    stk_sp;
  logic              stk_full;
  logic              stk_empty;
  logic [PCW-1:0]    stk_top;

  assign cls       = decode(ir);
  assign op        = ir[2:0];
  assign halted    = (state == ST_HALT);
  assign port_sel  = NPORTS'(1) << port_idx;
  // Only the addressed port's handshake bit counts; the others are masked off.
  assign in_hs     = |(in_valid & port_sel);
  assign out_hs    = |(out_ready & port_sel);
  assign push_data = pc_cur + PCW'(1);
  assign ret_addr  = (stk_sp != '0) ? stk_top : '0;

  uc_ret_stack #(
    .PCW         (PCW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .sp        (stk_sp),
    .full      (stk_full),
    .empty     (stk_empty),
    .top       (stk_top)
  );

  // NOTE: state is updated with non-blocking assignments so every process
  // sees the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FETCH;
      ir        <= OP_NOP;
      zr        <= 1'b0;
      cr        <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH) begin
        ir <= opcode;
      end
      if (flags_we) begin
        zr <= z_alu;
        cr <= c_alu;
      end
      if (err_set) begin
        stack_err <= 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no decode path
    // can leave one unassigned and infer a latch.
    state_nxt = state;
    we3       = 1'b0;
    s_inm     = 1'b0;
    s_e       = 1'b0;
    s_s       = 1'b0;
    s_mem_rd2 = 1'b0;
    pc_we     = 1'b0;
    s_pc      = SPC_INC;
    in_ready  = '0;
    out_valid = '0;
    flags_we  = 1'b0;
    err_set   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;

    case (state)
      ST_FETCH: state_nxt = ST_EXEC;

      ST_EXEC: begin
        state_nxt = ST_FETCH;
        case (cls)
          IC_FIN: state_nxt = ST_HALT;
          IC_ALU: begin
            we3      = 1'b1;
            pc_we    = 1'b1;
            flags_we = 1'b1;
          end
          IC_LDI: begin
            we3   = 1'b1;
            s_inm = 1'b1;
            pc_we = 1'b1;
          end
          IC_JMP: begin
            pc_we = 1'b1;
            s_pc  = SPC_IMM;
          end
          IC_JZ: begin
            pc_we = 1'b1;
            s_pc  = zr ? SPC_IMM : SPC_INC;
          end
          IC_JNZ: begin
            pc_we = 1'b1;
            s_pc  = zr ? SPC_INC : SPC_IMM;
          end
          IC_JC: begin
            pc_we = 1'b1;
            s_pc  = cr ? SPC_IMM : SPC_INC;
          end
          IC_JNC: begin
            pc_we = 1'b1;
            s_pc  = cr ? SPC_INC : SPC_IMM;
          end
          IC_CALL: begin
            // A stack fault freezes the machine with the PC untouched.
            if (stk_full) begin
              err_set   = 1'b1;
              state_nxt = ST_HALT;
            end else begin
              push  = 1'b1;
              pc_we = 1'b1;
              s_pc  = SPC_IMM;
            end
          end
          IC_RET: begin
            if (stk_empty) begin
              err_set   = 1'b1;
              state_nxt = ST_HALT;
            end else begin
              pop   = 1'b1;
              pc_we = 1'b1;
              s_pc  = SPC_RET;
            end
          end
          IC_OUTI, IC_OUTR: begin
            s_s       = 1'b1;
            s_mem_rd2 = (cls == IC_OUTR);
            out_valid = port_sel;
            if (out_hs) begin
              pc_we = 1'b1;
            end else begin
              state_nxt = ST_EXEC;
            end
          end
          IC_IN: begin
            in_ready = port_sel;
            if (in_hs) begin
              we3   = 1'b1;
              s_e   = 1'b1;
              pc_we = 1'b1;
            end else begin
              state_nxt = ST_EXEC;
            end
          end
          default: pc_we = 1'b1;
        endcase
      end

      ST_HALT: state_nxt = ST_HALT;

      default: state_nxt = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_uc_seq_ctrl.sv
// Self-checking bench for uc_seq_ctrl: directed steps from the test plan, then
// random instruction streams checked against an instruction-level model.
module tb_uc_seq_ctrl;

  localparam int PCW   = 10;
  localparam int DEPTH = 8;
  localparam int NP    = 4;

  localparam logic [5:0] C_FIN  = 6'b111111;
  localparam logic [5:0] C_NOP  = 6'b111110;
  localparam logic [5:0] C_ALU2 = 6'b000010;
  localparam logic [5:0] C_LDI  = 6'b001000;
  localparam logic [5:0] C_JMP  = 6'b001001;
  localparam logic [5:0] C_JZ   = 6'b001010;
  localparam logic [5:0] C_JNZ  = 6'b001011;
  localparam logic [5:0] C_JC   = 6'b011001;
  localparam logic [5:0] C_JNC  = 6'b011010;
  localparam logic [5:0] C_CALL = 6'b101001;
  localparam logic [5:0] C_RET  = 6'b101010;
  localparam logic [5:0] C_OUTI = 6'b001100;
  localparam logic [5:0] C_OUTR = 6'b001110;
  localparam logic [5:0] C_IN   = 6'b011110;

  logic           clk;
  logic           reset;
  logic [5:0]     opcode;
  logic [1:0]     port_idx;
  logic [PCW-1:0] pc_cur;
  logic           z_alu;
  logic           c_alu;
  logic [2:0]     op;
  logic           we3;
  logic           s_inm;
  logic           s_e;
  logic           s_s;
  logic           s_mem_rd2;
  logic           pc_we;
  logic [1:0]     s_pc;
  logic [PCW-1:0] ret_addr;
  logic [NP-1:0]  in_ready;
  logic [NP-1:0]  in_valid;
  logic [NP-1:0]  out_valid;
  logic [NP-1:0]  out_ready;
  logic           halted;
  logic           stack_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic          we3;
    logic          s_inm;
    logic          s_e;
    logic          s_s;
    logic          s_mem_rd2;
    logic          pc_we;
    logic [1:0]    s_pc;
    logic [NP-1:0] in_ready;
    logic [NP-1:0] out_valid;
    logic          halted;
    logic          stack_err;
  } outs_t;

  typedef enum {
    M_FIN, M_NOP, M_ALU, M_LDI, M_JMP, M_JZ, M_JNZ, M_JC, M_JNC,
    M_CALL, M_RET, M_OUTI, M_OUTR, M_IN
  } mn_t;

  // Instruction-level reference state.
  logic           m_zr;
  logic           m_cr;
  logic           m_halted;
  logic           m_err;
  logic [PCW-1:0] m_stack[$];

  uc_seq_ctrl #(
    .PCW         (PCW),
    .STACK_DEPTH (DEPTH),
    .NPORTS      (NP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .port_idx  (port_idx),
    .pc_cur    (pc_cur),
    .z_alu     (z_alu),
    .c_alu     (c_alu),
    .op        (op),
    .we3       (we3),
    .s_inm     (s_inm),
    .s_e       (s_e),
    .s_s       (s_s),
    .s_mem_rd2 (s_mem_rd2),
    .pc_we     (pc_we),
    .s_pc      (s_pc),
    .ret_addr  (ret_addr),
    .in_ready  (in_ready),
    .in_valid  (in_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted),
    .stack_err (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mn_t classify(input logic [5:0] o);
    case (o)
      C_FIN:  return M_FIN;
      C_NOP:  return M_NOP;
      C_JMP:  return M_JMP;
      C_JZ:   return M_JZ;
      C_JNZ:  return M_JNZ;
      C_JC:   return M_JC;
      C_JNC:  return M_JNC;
      C_CALL: return M_CALL;
      C_RET:  return M_RET;
      C_OUTR: return M_OUTR;
      C_IN:   return M_IN;
      default: begin
        if (o[3] == 1'b0)        return M_ALU;
        if (o[2:0] == 3'b000)    return M_LDI;
        if (o[2:0] == 3'b100)    return M_OUTI;
        return M_NOP;
      end
    endcase
  endfunction

  function automatic logic [NP-1:0] onehot(input logic [1:0] i);
    logic [NP-1:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  function automatic outs_t dut_outs();
    return {we3, s_inm, s_e, s_s, s_mem_rd2, pc_we, s_pc, in_ready, out_valid,
            halted, stack_err};
  endfunction

  function automatic outs_t idle();
    outs_t e;
    e = '0;
    e.halted    = m_halted;
    e.stack_err = m_err;
    return e;
  endfunction

  function automatic outs_t io_expect(input mn_t mn, input logic [NP-1:0] sel, input logic hs);
    outs_t e;
    e = idle();
    if (mn == M_IN) begin
      e.in_ready = sel;
      e.we3      = hs;
      e.s_e      = hs;
      e.pc_we    = hs;
    end else begin
      e.s_s       = 1'b1;
      e.s_mem_rd2 = (mn == M_OUTR);
      e.out_valid = sel;
      e.pc_we     = hs;
    end
    return e;
  endfunction

  // Called at a falling edge with the DUT in reset; leaves it in FETCH.
  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    @(negedge clk);
    reset = 1'b0;
    m_stack.delete();
    m_zr     = 1'b0;
    m_cr     = 1'b0;
    m_halted = 1'b0;
    m_err    = 1'b0;
    #1;
    check("reset outs", dut_outs(), idle());
    check("reset op", op, 3'b110);
  endtask

  // One full instruction: FETCH cycle, EXEC (with optional I/O wait cycles),
  // then returns at the falling edge that starts the next instruction.
  task automatic do_instr(input logic [5:0] opc, input int waits, input logic [1:0] pidx,
                          input logic [PCW-1:0] pc, input logic zin, input logic cin);
    mn_t            mn;
    outs_t          e;
    logic [NP-1:0]  sel;
    logic [PCW-1:0] nxt;
    mn        = classify(opc);
    sel       = onehot(pidx);
    opcode    = opc;
    port_idx  = pidx;
    pc_cur    = pc;
    z_alu     = 1'($urandom);
    c_alu     = 1'($urandom);
    in_valid  = '0;
    out_ready = '0;
    #1;
    if (m_halted) begin
      check("halted idle", dut_outs(), idle());
      @(negedge clk);
      return;
    end
    check({"fetch ", mn.name()}, dut_outs(), idle());
    if (m_stack.size() > 0) check("fetch ret_addr", ret_addr, m_stack[$]);
    @(negedge clk);

    // IR must hold the latched opcode, so the bus is scrambled during EXEC.
    opcode = 6'($urandom);
    z_alu  = zin;
    c_alu  = cin;

    if (mn == M_IN || mn == M_OUTI || mn == M_OUTR) begin
      for (int i = 0; i < waits; i++) begin
        in_valid  = NP'($urandom);
        out_ready = NP'($urandom);
        if (mn == M_IN) in_valid = in_valid & ~sel;
        else            out_ready = out_ready & ~sel;
        #1;
        check({"wait ", mn.name()}, dut_outs(), io_expect(mn, sel, 1'b0));
        @(negedge clk);
      end
      if (mn == M_IN) in_valid = in_valid | sel;
      else            out_ready = out_ready | sel;
      #1;
      check({"handshake ", mn.name()}, dut_outs(), io_expect(mn, sel, 1'b1));
      check("exec op", op, opc[2:0]);
      @(negedge clk);
      return;
    end

    #1;
    e = idle();
    case (mn)
      M_FIN: ;
      M_ALU: begin e.we3 = 1'b1; e.pc_we = 1'b1; end
      M_LDI: begin e.we3 = 1'b1; e.s_inm = 1'b1; e.pc_we = 1'b1; end
      M_JMP: begin e.pc_we = 1'b1; e.s_pc = 2'b01; end
      M_JZ:  begin e.pc_we = 1'b1; e.s_pc = m_zr ? 2'b01 : 2'b00; end
      M_JNZ: begin e.pc_we = 1'b1; e.s_pc = m_zr ? 2'b00 : 2'b01; end
      M_JC:  begin e.pc_we = 1'b1; e.s_pc = m_cr ? 2'b01 : 2'b00; end
      M_JNC: begin e.pc_we = 1'b1; e.s_pc = m_cr ? 2'b00 : 2'b01; end
      M_CALL: begin
        if (m_stack.size() < DEPTH) begin e.pc_we = 1'b1; e.s_pc = 2'b01; end
      end
      M_RET: begin
        if (m_stack.size() > 0) begin
          e.pc_we = 1'b1;
          e.s_pc  = 2'b10;
          check("RET ret_addr", ret_addr, m_stack[$]);
        end
      end
      default: e.pc_we = 1'b1;
    endcase
    check({"exec ", mn.name()}, dut_outs(), e);
    check("exec op", op, opc[2:0]);

    case (mn)
      M_FIN: m_halted = 1'b1;
      M_ALU: begin m_zr = zin; m_cr = cin; end
      M_CALL: begin
        if (m_stack.size() < DEPTH) begin
          nxt = pc + 1'b1;
          m_stack.push_back(nxt);
        end else begin
          m_err    = 1'b1;
          m_halted = 1'b1;
        end
      end
      M_RET: begin
        if (m_stack.size() > 0) begin
          void'(m_stack.pop_back());
        end else begin
          m_err    = 1'b1;
          m_halted = 1'b1;
        end
      end
      default: ;
    endcase
    @(negedge clk);
  endtask

  initial begin
    outs_t      e;
    logic [5:0] r;
    reset     = 1'b1;
    opcode    = '0;
    port_idx  = '0;
    pc_cur    = '0;
    z_alu     = 1'b0;
    c_alu     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    @(negedge clk);
    do_reset();

    // ALU sets Z=1, C=0; then the flag-conditional jumps.
    do_instr(C_ALU2, 0, 2'd0, 10'h010, 1'b1, 1'b0);
    do_instr(C_JZ,   0, 2'd0, 10'h011, 1'b0, 1'b1);
    do_instr(C_JNZ,  0, 2'd0, 10'h012, 1'b0, 1'b1);
    do_instr(C_JC,   0, 2'd0, 10'h013, 1'b1, 1'b1);
    do_instr(C_JNC,  0, 2'd0, 10'h014, 1'b1, 1'b1);
    do_instr(C_LDI,  0, 2'd0, 10'h015, 1'b0, 1'b0);
    do_instr(C_JMP,  0, 2'd0, 10'h016, 1'b0, 1'b0);
    do_instr(C_OUTI, 2, 2'd3, 10'h017, 1'b0, 1'b0);

    // CALL at the top of the address space wraps the return address to 0.
    do_instr(C_CALL, 0, 2'd0, 10'h3FF, 1'b0, 1'b0);
    do_instr(C_RET,  0, 2'd0, 10'h100, 1'b0, 1'b0);
    do_instr(C_RET,  0, 2'd0, 10'h101, 1'b0, 1'b0);
    do_instr(C_NOP,  0, 2'd0, 10'h102, 1'b0, 1'b0);
    do_reset();

    // Eight nested calls fit; the ninth overflows and halts.
    for (int i = 0; i < DEPTH + 1; i++) begin
      do_instr(C_CALL, 0, 2'd0, PCW'(i * 37 + 5), 1'b0, 1'b0);
    end
    do_instr(C_NOP, 0, 2'd0, 10'h000, 1'b0, 1'b0);
    do_instr(C_NOP, 0, 2'd0, 10'h000, 1'b0, 1'b0);
    do_reset();

    // IN on port 2 stalls five cycles, then handshakes once.
    do_instr(C_IN,  5, 2'd2, 10'h020, 1'b0, 1'b0);
    do_instr(C_NOP, 0, 2'd0, 10'h021, 1'b0, 1'b0);

    // OUT register on port 1 with reset landing during the wait.
    opcode    = C_OUTR;
    port_idx  = 2'd1;
    in_valid  = '0;
    out_ready = '0;
    #1;
    check("outr fetch", dut_outs(), idle());
    @(negedge clk);
    opcode    = 6'($urandom);
    out_ready = 4'b1101;
    #1;
    e = idle();
    e.s_s       = 1'b1;
    e.s_mem_rd2 = 1'b1;
    e.out_valid = 4'b0010;
    check("outr wait", dut_outs(), e);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 4'b0010;
    m_stack.delete();
    m_zr     = 1'b0;
    m_cr     = 1'b0;
    m_halted = 1'b0;
    m_err    = 1'b0;
    #1;
    check("outr after reset", dut_outs(), idle());
    check("outr after reset op", op, 3'b110);
    do_instr(C_FIN, 0, 2'd0, 10'h030, 1'b0, 1'b0);
    do_instr(C_NOP, 0, 2'd0, 10'h031, 1'b0, 1'b0);
    do_instr(C_IN,  0, 2'd0, 10'h032, 1'b0, 1'b0);
    do_reset();

    // Random instruction stream; FIN is kept rare so programs run a while.
    for (int n = 0; n < 300; n++) begin
      r = 6'($urandom_range(0, 63));
      if (r == C_FIN && $urandom_range(0, 9) != 0) r = C_NOP;
      do_instr(r, $urandom_range(0, 3), 2'($urandom), PCW'($urandom),
               1'($urandom), 1'($urandom));
      if (m_halted) begin
        do_instr(6'($urandom), 0, 2'd0, '0, 1'b0, 1'b0);
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
